// File: rtl/serial_comparador.sv
// serial_comparador: bit-serial unsigned compare of two LSB-first operands, reporting eq/gt/lt with a done pulse
module serial_comparador #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [CNT_W-1:0] bit_count
);
    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;
    state_t state, state_n;
    logic eq_acc, gt_acc, lt_acc, take, last, diff, eq_n, gt_n, lt_n;
    always_comb begin
        take = state == COMPARE && bit_valid;
        last = take && bit_count == CNT_W'(WIDTH - 1);
        diff = a_bit ^ b_bit;
        eq_n = eq_acc & ~diff;
        // a differing bit arriving later is more significant, so it overrides
        gt_n = diff ? a_bit : gt_acc;
        lt_n = diff ? b_bit : lt_acc;
        state_n = state == IDLE    ? (start ? COMPARE : IDLE) :
                  state == COMPARE ? (last ? DONE : COMPARE) : IDLE;
        busy = state == COMPARE;
        done = state == DONE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            bit_count <= '0;
            {eq_acc, gt_acc, lt_acc} <= 3'b000;
            {eq, gt, lt} <= 3'b000;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                bit_count <= '0;
                {eq_acc, gt_acc, lt_acc} <= 3'b100;
            end
            if (state == COMPARE) begin
                {eq, gt, lt} <= last ? {eq_n, gt_n, lt_n} : 3'b000;
                if (take) begin
                    {eq_acc, gt_acc, lt_acc} <= {eq_n, gt_n, lt_n};
                    bit_count <= last ? '0 : bit_count + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_comparador.sv
// tb_serial_comparador: randomized and directed checks of serial_comparador against an arithmetic reference
module tb_serial_comparador;
    logic clk = 0, rst = 1, start = 0, bit_valid = 0, a_bit = 0, b_bit = 0;
    logic busy, done, eq, gt, lt;
    logic [2:0] bit_count;
    int n_cmp = 0, n_bad = 0;
    logic [2:0] prev_res = 3'b000;

    serial_comparador #(.WIDTH(6), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .a_bit(a_bit), .b_bit(b_bit),
        .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt), .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] ref_res(input logic [5:0] a, input logic [5:0] b);
        return {a == b, a > b, a < b};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // st holds a 2-bit stall count to insert after each pair; noise toggles start where it must be ignored
    task automatic run_op(input logic [5:0] a, input logic [5:0] b, input logic [11:0] st, input bit noise,
                          output int lat, output int dw, output logic [2:0] res, output logic [2:0] held,
                          output logic [2:0] cleared, output int busy_bad, output int cnt_bad);
        int edges, n;
        edges = 0; busy_bad = 0; cnt_bad = 0; cleared = 3'bxxx;
        start = 1; step; edges++; start = 0;
        held = {eq, gt, lt};
        if (!busy) busy_bad++;
        for (int i = 0; i < 6; i++) begin
            if (bit_count !== 3'(i)) cnt_bad++;
            bit_valid = 1; a_bit = a[i]; b_bit = b[i];
            step; edges++;
            bit_valid = 0;
            if (i == 0) cleared = {eq, gt, lt};
            if (i < 5) begin
                if (!busy) busy_bad++;
                for (int s = 0; s < int'(st[2*i +: 2]); s++) begin
                    start = noise ? 1'($urandom) : 1'b0;
                    a_bit = 1'($urandom); b_bit = 1'($urandom);
                    step; edges++;
                    start = 0;
                    if (!busy) busy_bad++;
                    if (bit_count !== 3'(i + 1)) cnt_bad++;
                end
                start = noise ? 1'($urandom) : 1'b0;
            end
        end
        start = 0;
        n = 0;
        while (!done && n < 4) begin step; edges++; n++; end
        lat = edges;
        res = {eq, gt, lt};
        if (bit_count !== 3'd0) cnt_bad++;
        if (busy) busy_bad++;
        dw = done ? 1 : 0;
        start = noise;
        step;
        start = 0;
        for (int k = 0; k < 3; k++) begin
            if (done) dw++;
            if (busy) busy_bad++;
            if (k < 2) step;
        end
    endtask

    task automatic test_reset;
        n_cmp++; if ({busy, done, eq, gt, lt} !== 5'b0) begin n_bad++; $display("FAIL reset_outs got %b exp 00000", {busy, done, eq, gt, lt}); end
        n_cmp++; if (bit_count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", bit_count); end
        step; rst = 0; step;
        n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL idle_after_reset got %b exp 00", {busy, done}); end
    endtask

    task automatic test_directed;
        logic [5:0] av [3] = '{6'b100111, 6'b101010, 6'b000001};
        logic [5:0] bv [3] = '{6'b100111, 6'b010101, 6'b100000};
        logic [2:0] ev [3] = '{3'b100, 3'b010, 3'b001};
        int lat, dw, bb, cb;
        logic [2:0] res, held, clr;
        for (int t = 0; t < 3; t++) begin
            run_op(av[t], bv[t], 12'h0, 0, lat, dw, res, held, clr, bb, cb);
            n_cmp++; if (res !== ev[t] || res !== ref_res(av[t], bv[t])) begin n_bad++; $display("FAIL dir%0d_res got %b exp %b", t, res, ev[t]); end
            n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL dir%0d_latency got %0d exp 7", t, lat); end
            n_cmp++; if (dw !== 1) begin n_bad++; $display("FAIL dir%0d_done_width got %0d exp 1", t, dw); end
            n_cmp++; if (held !== prev_res) begin n_bad++; $display("FAIL dir%0d_held got %b exp %b", t, held, prev_res); end
            n_cmp++; if (clr !== 3'b000) begin n_bad++; $display("FAIL dir%0d_cleared got %b exp 000", t, clr); end
            n_cmp++; if (bb !== 0 || cb !== 0) begin n_bad++; $display("FAIL dir%0d_busy_count got %0d/%0d exp 0/0", t, bb, cb); end
            prev_res = ev[t];
        end
    endtask

    task automatic test_stalls;
        int lat, dw, bb, cb;
        logic [2:0] res, held, clr;
        run_op(6'b100111, 6'b100111, 12'h30C, 0, lat, dw, res, held, clr, bb, cb);
        n_cmp++; if (res !== 3'b100) begin n_bad++; $display("FAIL stall_res got %b exp 100", res); end
        n_cmp++; if (lat !== 13) begin n_bad++; $display("FAIL stall_latency got %0d exp 13", lat); end
        n_cmp++; if (bb !== 0 || cb !== 0) begin n_bad++; $display("FAIL stall_busy_count got %0d/%0d exp 0/0", bb, cb); end
        prev_res = 3'b100;
    endtask

    task automatic test_guards;
        int lat, dw, bb, cb;
        logic [2:0] res, held, clr;
        for (int k = 0; k < 4; k++) begin
            bit_valid = 1; a_bit = 1'($urandom); b_bit = 1'($urandom);
            step;
        end
        bit_valid = 0;
        n_cmp++; if ({busy, done} !== 2'b00 || bit_count !== 3'd0) begin n_bad++; $display("FAIL idle_valid got busy/done %b cnt %0d exp 00 0", {busy, done}, bit_count); end
        n_cmp++; if ({eq, gt, lt} !== prev_res) begin n_bad++; $display("FAIL idle_hold got %b exp %b", {eq, gt, lt}, prev_res); end
        run_op(6'b110000, 6'b101111, 12'h555, 1, lat, dw, res, held, clr, bb, cb);
        n_cmp++; if (res !== 3'b010) begin n_bad++; $display("FAIL guard_res got %b exp 010", res); end
        n_cmp++; if (lat !== 12 || dw !== 1) begin n_bad++; $display("FAIL guard_timing got lat %0d dw %0d exp 12 1", lat, dw); end
        n_cmp++; if (bb !== 0 || cb !== 0) begin n_bad++; $display("FAIL guard_busy_count got %0d/%0d exp 0/0", bb, cb); end
        prev_res = 3'b010;
    endtask

    task automatic test_back_to_back;
        int lat, dw, bb, cb;
        logic [2:0] res, held, clr;
        run_op(6'b011100, 6'b001100, 12'h0, 0, lat, dw, res, held, clr, bb, cb);
        n_cmp++; if (res !== 3'b010 || dw !== 1) begin n_bad++; $display("FAIL b2b_first got %b dw %0d exp 010 1", res, dw); end
        run_op(6'b011100, 6'b011100, 12'h0, 0, lat, dw, res, held, clr, bb, cb);
        n_cmp++; if (held !== 3'b010) begin n_bad++; $display("FAIL b2b_held got %b exp 010", held); end
        n_cmp++; if (res !== 3'b100 || dw !== 1) begin n_bad++; $display("FAIL b2b_second got %b dw %0d exp 100 1", res, dw); end
        prev_res = 3'b100;
    endtask

    task automatic test_reset_mid;
        int lat, dw, bb, cb, dones;
        logic [2:0] res, held, clr;
        start = 1; step; start = 0;
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1; a_bit = 1'($urandom); b_bit = 1'($urandom);
            step;
        end
        bit_valid = 0;
        #3 rst = 1;
        #1;
        n_cmp++; if ({busy, done, eq, gt, lt} !== 5'b0 || bit_count !== 3'd0) begin n_bad++; $display("FAIL async_reset got %b cnt %0d exp 00000 0", {busy, done, eq, gt, lt}, bit_count); end
        dones = 0;
        for (int k = 0; k < 3; k++) begin step; if (done) dones++; end
        rst = 0;
        for (int k = 0; k < 8; k++) begin step; if (done || busy) dones++; end
        n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL reset_no_done got %0d exp 0", dones); end
        prev_res = 3'b000;
        run_op(6'b111111, 6'b111110, 12'h0, 0, lat, dw, res, held, clr, bb, cb);
        n_cmp++; if (res !== 3'b010 || held !== 3'b000) begin n_bad++; $display("FAIL post_reset got %b held %b exp 010 000", res, held); end
        prev_res = 3'b010;
    endtask

    task automatic test_random;
        int lat, dw, bb, cb, stall_sum;
        logic [5:0] a, b;
        logic [11:0] st;
        logic [2:0] res, held, clr, exp;
        for (int t = 0; t < 40; t++) begin
            a = 6'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : 6'($urandom);
            st = ($urandom_range(0, 1) == 0) ? 12'h0 : 12'($urandom);
            st[11:10] = 2'b00;
            stall_sum = 0;
            for (int i = 0; i < 5; i++) stall_sum += int'(st[2*i +: 2]);
            exp = ref_res(a, b);
            run_op(a, b, st, 1, lat, dw, res, held, clr, bb, cb);
            n_cmp++; if (res !== exp) begin n_bad++; $display("FAIL rnd%0d_res a=%b b=%b got %b exp %b", t, a, b, res, exp); end
            n_cmp++; if (lat !== 7 + stall_sum || dw !== 1) begin n_bad++; $display("FAIL rnd%0d_timing got lat %0d dw %0d exp %0d 1", t, lat, dw, 7 + stall_sum); end
            n_cmp++; if (held !== prev_res || clr !== 3'b000) begin n_bad++; $display("FAIL rnd%0d_hold got %b/%b exp %b/000", t, held, clr, prev_res); end
            n_cmp++; if (bb !== 0 || cb !== 0) begin n_bad++; $display("FAIL rnd%0d_busy_count got %0d/%0d exp 0/0", t, bb, cb); end
            prev_res = exp;
        end
    endtask

    initial begin
        #2;
        test_reset;
        test_directed;
        test_stalls;
        test_guards;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_comparador.md
Name: serial_comparador

Overview:
Bit-serial magnitude/equality comparator. It is the sequential counterpart of the parallel 6-bit XNOR equality comparator.
- Two operands arrive one bit pair per accepted cycle, LSB first, from an upstream serializer using a valid strobe.
- After WIDTH pairs it reports equal, greater or less, and pulses done.
- Used where operands are streamed rather than presented as parallel words.

Parameters:
WIDTH, 6, operand width in bits (>= 2).
CNT_W, 3, bit counter width; must satisfy 2**CNT_W > WIDTH-1.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
start  input  1  begin a new comparison; sampled only in IDLE.
bit_valid  input  1  a_bit/b_bit hold a valid pair this cycle.
a_bit  input  1  current bit of operand A (LSB first).
b_bit  input  1  current bit of operand B (LSB first).
busy  output  1  high while in COMPARE.
done  output  1  one-cycle pulse: result registers just updated.
eq  output  1  A == B (registered, held).
gt  output  1  A > B unsigned (registered, held).
lt  output  1  A < B unsigned (registered, held).
bit_count  output  CNT_W  number of pairs accepted in the current comparison.

Behaviour:
- One clock (clk). rst is asynchronous and active-high; its assertion forces the reset state immediately, independent of clk.
- Reset state: IDLE; busy=0, done=0, eq=0, gt=0, lt=0, bit_count=0; internal accumulators cleared.
- FSM states: IDLE, COMPARE, DONE.
- IDLE:
  - bit_valid is ignored.
  - start=1 -> COMPARE at the next edge, with bit_count=0, eq_acc=1, gt_acc=0, lt_acc=0.
  - eq/gt/lt keep the previous result until the first edge in COMPARE, then clear to 0.
- COMPARE (busy=1):
  - On each edge with bit_valid=1:
    - eq_acc <= eq_acc & ~(a_bit ^ b_bit).
    - If a_bit != b_bit: gt_acc <= a_bit and lt_acc <= b_bit. A later, more significant differing bit overrides earlier ones.
    - bit_count increments.
  - bit_valid=0 stalls: no state change, no timeout.
  - start is ignored.
- Completion:
  - On the edge accepting the WIDTH-th pair (bit_count == WIDTH-1 and bit_valid=1), go to DONE.
  - On that same edge, eq/gt/lt are loaded from the final accumulator values including that last pair.
  - bit_count wraps to 0.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then return to IDLE.
  - start and bit_valid are ignored.
  - Consequence: minimum start-to-start spacing is WIDTH+2 cycles.
- Latency: done is high in the cycle after the edge that accepts the last pair, i.e. WIDTH+1 edges after start is accepted when there are no stalls.
- Result invariant: after any done, exactly one of eq/gt/lt is 1. Results hold until the next comparison's first COMPARE edge, or until reset.
- Reset mid-operation: abort immediately to the reset state; no done pulse is generated; partial results are discarded.

Test Plan:
- Equal operands: start, then stream A=100111, B=100111 LSB first, no stalls -> done on cycle 7 after start, eq=1, gt=0, lt=0; bit_count back to 0.
- Distinct operands: A=101010, B=010101 -> done with gt=1, eq=0, lt=0, since the MSB difference overrides the LSB difference where B=1.
- Less-than with late MSB: A=000001, B=100000 -> lt=1. Confirms the LSB difference (A larger) is overridden by the MSB difference.
- Stalls: same vectors as the first scenario, with bit_valid=0 for 3 cycles after the 2nd and 5th pairs -> done 6 cycles later than in the first scenario; result unchanged (eq=1); busy high throughout.
- Protocol guards:
  - start pulsed during COMPARE and in the DONE cycle -> ignored; bit_count unaffected.
  - bit_valid pulses in IDLE -> no state change.
  - Back-to-back comparisons (gt case, then eq case) -> second result replaces first; each done is exactly 1 cycle.
- Reset mid-operation: assert rst asynchronously (off-edge) after 3 pairs -> outputs 0 immediately; no done. A following full comparison with A=111111, B=111110 -> gt=1.
